// File: rtl/mos6502_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mos6502_arb_pkg : shared types and defaults for the 6502 bus arbiter     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mos6502_arb_pkg;

  localparam int c_ADDR_W_DEF = 16;
  localparam int c_DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    CPU      = 3'd0,
    H_ADDR   = 3'd1,
    H_WAIT   = 3'd2,
    H_DONE   = 3'd3,
    C_RESUME = 3'd4
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mos6502_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mos6502_bus_arbiter : shares the memory pads between the 6502 core and a |
// | host loader port, stalling the core via RDY. Rev 1.0                     |
// +--------------------------------------------------------------------------+
module mos6502_bus_arbiter
  import mos6502_arb_pkg::*;
#(
  parameter int ADDR_W      = c_ADDR_W_DEF,
  parameter int DATA_W      = c_DATA_W_DEF,
  parameter int HOST_WAIT   = 1,
  parameter int CPU_MIN_RUN = 2
) (
  input  logic              wb_clk_i,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_we,
  output logic              cpu_rdy,
  output logic [DATA_W-1:0] cpu_di,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_oeb,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_host
);

  localparam int c_WAIT_W = (HOST_WAIT > 0) ? $clog2(HOST_WAIT + 1) : 1;
  localparam int c_RUN_W  = $clog2(CPU_MIN_RUN + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_INIT = c_WAIT_W'((HOST_WAIT > 0) ? HOST_WAIT - 1 : 0);
  localparam logic [c_RUN_W-1:0]  c_RUN_MAX   = c_RUN_W'(CPU_MIN_RUN);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_RUN_W-1:0]  r_run_cnt;
  logic                r_host_we;
  logic [ADDR_W-1:0]   r_host_addr;
  logic [DATA_W-1:0]   r_host_wdata;
  logic [DATA_W-1:0]   r_cpu_di;
  logic                r_host_ack;
  logic [DATA_W-1:0]   r_host_rdata;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic                w_mem_we;
  logic                w_cpu_rdy;

  // Host is only taken on a CPU read cycle, after the core has had its minimum run.
  assign w_accept = (r_state == CPU) && host_req && !cpu_we && (r_run_cnt == c_RUN_MAX);

  always_ff @(posedge wb_clk_i) begin
    if (reset) r_state <= CPU;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_addr  = cpu_ab;
    w_mem_wdata = cpu_do;
    w_mem_we    = 1'b0;
    w_cpu_rdy   = 1'b0;
    case (r_state)
      CPU: begin
        w_mem_we  = cpu_we;
        w_cpu_rdy = 1'b1;
        if (w_accept) w_state_nxt = H_ADDR;
      end
      H_ADDR: begin
        w_mem_addr  = r_host_addr;
        w_mem_wdata = r_host_wdata;
        w_mem_we    = r_host_we;
        w_state_nxt = (HOST_WAIT > 0) ? H_WAIT : H_DONE;
      end
      H_WAIT: begin
        w_mem_addr  = r_host_addr;
        w_mem_wdata = r_host_wdata;
        w_mem_we    = r_host_we;
        if (r_wait_cnt == '0) w_state_nxt = H_DONE;
      end
      H_DONE: begin
        w_mem_addr  = r_host_addr;
        w_mem_wdata = r_host_wdata;
        w_state_nxt = C_RESUME;
      end
      C_RESUME: w_state_nxt = CPU;
      default:  w_state_nxt = CPU;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      r_run_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_host_we    <= 1'b0;
      r_host_addr  <= '0;
      r_host_wdata <= '0;
    end else begin
      if (r_state == CPU && r_run_cnt != c_RUN_MAX) r_run_cnt <= r_run_cnt + 1'b1;
      else if (r_state == C_RESUME)                 r_run_cnt <= '0;
      if (w_accept) begin
        r_host_we    <= host_we;
        r_host_addr  <= host_addr;
        r_host_wdata <= host_wdata;
      end
      if (r_state == H_ADDR)                          r_wait_cnt <= c_WAIT_INIT;
      else if (r_state == H_WAIT && r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  // C_RESUME re-reads the frozen CPU address so DI is valid on the first RDY=1 cycle.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      r_cpu_di     <= '0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_host_ack <= (r_state == H_DONE);
      if (r_state == H_DONE && !r_host_we) r_host_rdata <= mem_rdata;
      if ((r_state == CPU && !cpu_we) || r_state == C_RESUME) r_cpu_di <= mem_rdata;
    end
  end

  assign mem_addr   = w_mem_addr;
  assign mem_wdata  = w_mem_wdata;
  assign mem_we     = w_mem_we && !reset;
  assign mem_oeb    = !mem_we;
  assign cpu_rdy    = w_cpu_rdy || reset;
  assign cpu_di     = r_cpu_di;
  assign host_ack   = r_host_ack;
  assign host_rdata = r_host_rdata;
  assign grant_host = (r_state != CPU) && (r_state != C_RESUME);

endmodule
`default_nettype wire

// File: tb/tb_mos6502_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mos6502_bus_arbiter : scoreboard bench for the 6502 bus arbiter       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mos6502_bus_arbiter;

  typedef struct {
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  logic wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  logic        reset      = 1'b1;
  logic [15:0] cpu_ab     = 16'h0040;
  logic [7:0]  cpu_do     = 8'h00;
  logic        cpu_we     = 1'b1;
  logic        host_req   = 1'b0;
  logic        host_we    = 1'b0;
  logic [15:0] host_addr  = 16'h0000;
  logic [7:0]  host_wdata = 8'h00;
  logic        cpu_rdy, host_ack, mem_we, mem_oeb, grant_host;
  logic [7:0]  cpu_di, host_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  logic        host_req_0   = 1'b0;
  logic        host_we_0    = 1'b0;
  logic [15:0] host_addr_0  = 16'h0000;
  logic [7:0]  host_wdata_0 = 8'h00;
  logic        cpu_rdy_0, host_ack_0, mem_we_0, mem_oeb_0, grant_host_0;
  logic [7:0]  cpu_di_0, host_rdata_0, mem_wdata_0, mem_rdata_0;
  logic [15:0] mem_addr_0;

  logic [7:0] mem [0:65535];
  assign mem_rdata   = mem[mem_addr];
  assign mem_rdata_0 = mem[mem_addr_0];
  always @(posedge wb_clk_i) if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;

  int   cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [$];
  exp_t exp_q0 [$];
  exp_t mon_e, mon_e0;
  int   t0_0, lo_0;
  bit   got_0;
  logic [7:0] sum;

  mos6502_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .HOST_WAIT(1), .CPU_MIN_RUN(2)) dut (
    .wb_clk_i(wb_clk_i), .reset(reset), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_rdy(cpu_rdy), .cpu_di(cpu_di), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_oeb(mem_oeb), .mem_rdata(mem_rdata), .grant_host(grant_host)
  );

  mos6502_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .HOST_WAIT(0), .CPU_MIN_RUN(2)) dut0 (
    .wb_clk_i(wb_clk_i), .reset(reset), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_rdy(cpu_rdy_0), .cpu_di(cpu_di_0), .host_req(host_req_0), .host_we(host_we_0),
    .host_addr(host_addr_0), .host_wdata(host_wdata_0), .host_ack(host_ack_0),
    .host_rdata(host_rdata_0), .mem_addr(mem_addr_0), .mem_wdata(mem_wdata_0),
    .mem_we(mem_we_0), .mem_oeb(mem_oeb_0), .mem_rdata(mem_rdata_0),
    .grant_host(grant_host_0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Every ack must match the oldest outstanding expectation in data and cycle.
  always @(negedge wb_clk_i) begin
    if (host_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_rdata", {24'h0, host_rdata}, {24'h0, mon_e.rdata});
        chk("ack_cycle", cyc, mon_e.cyc);
      end
    end
  end

  always @(negedge wb_clk_i) begin
    if (host_ack_0 === 1'b1) begin
      if (exp_q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack0_unexpected actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon_e0 = exp_q0.pop_front();
        chk("ack0_rdata", {24'h0, host_rdata_0}, {24'h0, mon_e0.rdata});
        chk("ack0_cycle", cyc, mon_e0.cyc);
      end
    end
  end

  task automatic host_access(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                             input logic [7:0] exp_rdata, input int lat, input int hi_e,
                             input int lo_e, input int we_e);
    int t0, hi, lo, wc;
    bit got;
    t0 = cyc; hi = 0; lo = 0; wc = 0; got = 1'b0;
    host_we = we; host_addr = addr; host_wdata = wdata; host_req = 1'b1;
    exp_q.push_back('{exp_rdata, t0 + lat});
    for (int i = 0; i < 64 && !got; i++) begin
      tick();
      if (cpu_rdy) hi++; else lo++;
      if (mem_we && grant_host) wc++;
      if (host_ack) got = 1'b1;
    end
    host_req = 1'b0;
    chk("host_ack_seen", {31'h0, got}, 32'h1);
    chk("rdy_high_cycles", hi, hi_e);
    chk("rdy_low_cycles", lo, lo_e);
    chk("host_mem_we_cycles", wc, we_e);
  endtask

  task automatic cpu_cycle(input logic [15:0] ab, input logic [7:0] dout, input logic we);
    logic r;
    cpu_ab = ab; cpu_do = dout; cpu_we = we;
    for (int i = 0; i < 32; i++) begin
      r = cpu_rdy;
      tick();
      if (r) return;
    end
    checks++;
    errors++;
    $display("FAIL cpu_cycle_timeout actual=stalled expected=rdy (cycle %0d)", cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;
    mem[16'h0040] = 8'h11;
    mem[16'h0400] = 8'h77;
    for (int i = 0; i < 6; i++) mem[16'h0300 + i] = 8'(i + 1);

    // Reset held 3 cycles with the CPU asserting a write.
    repeat (3) tick();
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_oeb", {31'h0, mem_oeb}, 32'h1);
    chk("rst_cpu_rdy", {31'h0, cpu_rdy}, 32'h1);
    chk("rst_host_ack", {31'h0, host_ack}, 32'h0);
    chk("rst_cpu_di", {24'h0, cpu_di}, 32'h0);
    chk("rst_grant", {31'h0, grant_host}, 32'h0);
    chk("rst_host_rdata", {24'h0, host_rdata}, 32'h0);
    reset = 1'b0; cpu_we = 1'b0; cpu_ab = 16'h0040;

    // Host read right after reset; HOST_WAIT=0 instance in parallel.
    fork
      host_access(1'b0, 16'h1234, 8'h00, 8'hA5, 6, 2, 4, 0);
      begin
        t0_0 = cyc; lo_0 = 0; got_0 = 1'b0;
        host_we_0 = 1'b0; host_addr_0 = 16'h0040; host_req_0 = 1'b1;
        exp_q0.push_back('{8'h11, t0_0 + 5});
        for (int i = 0; i < 32 && !got_0; i++) begin
          tick();
          if (!cpu_rdy_0) lo_0++;
          if (host_ack_0) got_0 = 1'b1;
        end
        host_req_0 = 1'b0;
        chk("w0_ack_seen", {31'h0, got_0}, 32'h1);
        chk("w0_rdy_low_cycles", lo_0, 3);
      end
    join

    // Host write, then the CPU reads it back.
    host_access(1'b1, 16'h0200, 8'h5A, 8'hA5, 7, 3, 4, 2);
    cpu_cycle(16'h0200, 8'h00, 1'b0);
    chk("cpu_rd_0200", {24'h0, cpu_di}, 32'h5A);
    chk("mem_0200", {24'h0, mem[16'h0200]}, 32'h5A);

    // Host request during a run of CPU writes must wait for a read cycle.
    fork
      host_access(1'b0, 16'h1234, 8'h00, 8'hA5, 7, 3, 4, 0);
      begin
        for (int i = 0; i < 3; i++) begin
          cpu_ab = 16'(16'h0250 + i); cpu_do = 8'(8'hC3 + i); cpu_we = 1'b1;
          chk("wp_rdy", {31'h0, cpu_rdy}, 32'h1);
          chk("wp_grant", {31'h0, grant_host}, 32'h0);
          tick();
        end
        cpu_cycle(16'h0040, 8'h00, 1'b0);
      end
    join
    chk("wp_cpu_di", {24'h0, cpu_di}, 32'h11);
    chk("wp_mem_0250", {24'h0, mem[16'h0250]}, 32'hC3);
    chk("wp_mem_0251", {24'h0, mem[16'h0251]}, 32'hC4);
    chk("wp_mem_0252", {24'h0, mem[16'h0252]}, 32'hC5);

    // Continuous host pressure while the CPU sums a table.
    sum = 8'h00;
    fork
      begin
        host_access(1'b0, 16'h1234, 8'h00, 8'hA5, 7, 3, 4, 0);
        host_access(1'b0, 16'h0400, 8'h00, 8'h77, 7, 3, 4, 0);
        host_access(1'b0, 16'h1234, 8'h00, 8'hA5, 7, 3, 4, 0);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          cpu_cycle(16'(16'h0300 + i), 8'h00, 1'b0);
          sum = 8'(sum + cpu_di);
        end
      end
    join
    chk("prog_sum", {24'h0, sum}, 32'h15);

    // Reset while the host write sits in H_WAIT.
    host_we = 1'b1; host_addr = 16'h0260; host_wdata = 8'h99; host_req = 1'b1;
    repeat (5) tick();
    chk("mid_grant", {31'h0, grant_host}, 32'h1);
    chk("mid_mem_we", {31'h0, mem_we}, 32'h1);
    chk("mid_rdy", {31'h0, cpu_rdy}, 32'h0);
    reset = 1'b1;
    tick();
    chk("abort_grant", {31'h0, grant_host}, 32'h0);
    chk("abort_host_ack", {31'h0, host_ack}, 32'h0);
    chk("abort_mem_we", {31'h0, mem_we}, 32'h0);
    chk("abort_cpu_rdy", {31'h0, cpu_rdy}, 32'h1);
    chk("abort_host_rdata", {24'h0, host_rdata}, 32'h0);
    chk("abort_cpu_di", {24'h0, cpu_di}, 32'h0);
    reset = 1'b0; host_req = 1'b0; host_we = 1'b0;
    repeat (6) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("queue0_empty", exp_q0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
